// File: rtl/memunit_pkg.sv
// ---------------------------------------------------------------
// memunit_pkg : shared word width, command and state encodings
// Revision    : 1.0
// ---------------------------------------------------------------
`default_nettype none

package memunit_pkg;

   localparam int WORD = 16;

   localparam logic [1:0] BUS_NONE  = 2'b00;
   localparam logic [1:0] BUS_DRIVE = 2'b01;
   localparam logic [1:0] BUS_LOAD  = 2'b10;

   localparam logic [1:0] MDRM_NONE     = 2'b00;
   localparam logic [1:0] MDRM_FROM_MEM = 2'b01;
   localparam logic [1:0] MDRM_TO_WDATA = 2'b10;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic is_req(input logic [1:0] mode);
      return (mode == MEM_READ) || (mode == MEM_WRITE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/memunit_ram.sv
// ---------------------------------------------------------------
// memunit_ram : single-port synchronous array, registered read data
// Revision    : 1.0
// ---------------------------------------------------------------
`default_nettype none

module memunit_ram #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
   logic [WIDTH-1:0] rdata_q, rdata_d;

   // Array contents survive reset; only the read latch clears.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/memunit.sv
// ---------------------------------------------------------------
// memunit : MAR/MDR registers, wait-state access FSM and bus mux
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module memunit
   import memunit_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEPTH_LOG2  = 12,
   parameter int WAIT_STATES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   output logic             bus_err,
   input  logic [1:0]       MARBusMode,
   input  logic [1:0]       MDRBusMode,
   input  logic [1:0]       MDRMemMode,
   input  logic [1:0]       MemMode,
   output logic             mem_busy,
   output logic             mem_done,
   output logic [WIDTH-1:0] mar,
   output logic [WIDTH-1:0] mdr
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [WIDTH-1:0]      mar_q, mar_d;
   logic [WIDTH-1:0]      mdr_q, mdr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d;
   logic [WIDTH-1:0]      rdata;
   logic                  ram_we, ram_re;
   logic                  mar_drv, mdr_drv;

   always_comb begin
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      wdata_d = wdata_q;
      if (MARBusMode == BUS_LOAD) begin
         mar_d = bus_in;
      end
      // A bus load of MDR takes priority over a load from the read latch.
      if (MDRBusMode == BUS_LOAD) begin
         mdr_d = bus_in;
      end else if (MDRMemMode == MDRM_FROM_MEM) begin
         mdr_d = rdata;
      end
      if (MDRMemMode == MDRM_TO_WDATA) begin
         wdata_d = mdr_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      case (state_q)
         ST_IDLE: begin
            if (is_req(MemMode)) begin
               addr_d  = mar_q[DEPTH_LOG2-1:0];
               wr_d    = (MemMode == MEM_WRITE);
               cnt_d   = WAIT_CNT;
               state_d = (WAIT_CNT == 4'd0) ? ST_ACCESS : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
      end
   end

   assign ram_we = (state_q == ST_ACCESS) && wr_q;
   assign ram_re = (state_q == ST_ACCESS) && !wr_q;

   memunit_ram #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .rst_n (reset),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   // Bus outputs are forced low while reset is held, whatever the modes say.
   always_comb begin
      mar_drv = (MARBusMode == BUS_DRIVE);
      mdr_drv = (MDRBusMode == BUS_DRIVE);
      bus_oe  = reset && (mar_drv || mdr_drv);
      bus_err = reset && mar_drv && mdr_drv;
      bus_out = '0;
      if (bus_oe) begin
         bus_out = mdr_drv ? mdr_q : mar_q;
      end
   end

   assign mem_busy = (state_q != ST_IDLE);
   assign mem_done = (state_q == ST_DONE);
   assign mar      = mar_q;
   assign mdr      = mdr_q;

endmodule

`default_nettype wire

// File: tb/tb_memunit.sv
// ---------------------------------------------------------------
// tb_memunit : directed and randomized checks of memunit
// Revision   : 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_memunit;

   localparam int W  = 2;
   localparam int DL = 12;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] bus_in = '0;
   logic [1:0]  mar_mode = '0, mdr_mode = '0, mdrm = '0, mem = '0;
   logic [15:0] bus_out, mar, mdr;
   logic        bus_oe, bus_err, mem_busy, mem_done;

   logic [1:0]  z_mem = '0;
   logic [15:0] z_bus_out, z_mar, z_mdr;
   logic        z_bus_oe, z_bus_err, z_busy, z_done;

   int checks = 0;
   int errors = 0;

   // Reference state: m_age counts cycles since the request edge, 0 = idle.
   logic [15:0] m_mar = '0, m_mdr = '0, m_wdata = '0, m_rdata = '0;
   logic [11:0] m_addr = '0;
   bit          m_wr = 1'b0;
   int          m_age = 0;
   logic [15:0] m_mem [int];

   memunit #(.WIDTH(16), .DEPTH_LOG2(DL), .WAIT_STATES(W)) u_dut (
      .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out),
      .bus_oe(bus_oe), .bus_err(bus_err), .MARBusMode(mar_mode),
      .MDRBusMode(mdr_mode), .MDRMemMode(mdrm), .MemMode(mem),
      .mem_busy(mem_busy), .mem_done(mem_done), .mar(mar), .mdr(mdr)
   );

   memunit #(.WIDTH(16), .DEPTH_LOG2(DL), .WAIT_STATES(0)) u_dut_w0 (
      .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(z_bus_out),
      .bus_oe(z_bus_oe), .bus_err(z_bus_err), .MARBusMode(2'b00),
      .MDRBusMode(2'b00), .MDRMemMode(2'b00), .MemMode(z_mem),
      .mem_busy(z_busy), .mem_done(z_done), .mar(z_mar), .mdr(z_mdr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mar = '0; m_mdr = '0; m_wdata = '0; m_rdata = '0;
      m_addr = '0; m_age = 0;
   endtask

   task automatic model_edge();
      logic [15:0] o_mar, o_mdr, o_rd;
      bit acc;
      o_mar = m_mar; o_mdr = m_mdr; o_rd = m_rdata;
      acc = (m_age == 0) && (mem == 2'b01 || mem == 2'b10);
      if (m_age == W + 1) begin
         if (m_wr) m_mem[int'(m_addr)] = m_wdata;
         else      m_rdata = m_mem.exists(int'(m_addr)) ? m_mem[int'(m_addr)] : 16'h0;
      end
      if (mar_mode == 2'b10) m_mar = bus_in;
      if (mdr_mode == 2'b10)  m_mdr = bus_in;
      else if (mdrm == 2'b01) m_mdr = o_rd;
      if (mdrm == 2'b10) m_wdata = o_mdr;
      if (acc) begin
         m_age = 1; m_addr = o_mar[11:0]; m_wr = (mem == 2'b10);
      end else if (m_age == W + 2) begin
         m_age = 0;
      end else if (m_age != 0) begin
         m_age++;
      end
   endtask

   task automatic compare_all();
      bit dm, dd, e_oe, e_err;
      logic [15:0] e_out;
      dm = (mar_mode == 2'b01);
      dd = (mdr_mode == 2'b01);
      e_oe  = reset && (dm || dd);
      e_err = reset && dm && dd;
      e_out = !e_oe ? 16'h0 : (dd ? m_mdr : m_mar);
      chk("bus_out", 32'(bus_out), 32'(e_out));
      chk("bus_oe", 32'(bus_oe), 32'(e_oe));
      chk("bus_err", 32'(bus_err), 32'(e_err));
      chk("mem_busy", 32'(mem_busy), 32'(m_age != 0));
      chk("mem_done", 32'(mem_done), 32'(m_age == W + 2));
      chk("mar", 32'(mar), 32'(m_mar));
      chk("mdr", 32'(mdr), 32'(m_mdr));
   endtask

   always @(negedge clk) compare_all();

   task automatic cycle();
      @(posedge clk);
      if (reset) model_edge();
      #1;
   endtask

   task automatic set(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                      input logic [1:0] d, input logic [15:0] v);
      mar_mode = a; mdr_mode = b; mdrm = c; mem = d; bus_in = v;
   endtask

   task automatic idle();
      set(2'b00, 2'b00, 2'b00, 2'b00, 16'h0);
   endtask

   // Full access; returns in the first IDLE cycle, reads leave the data in MDR.
   task automatic do_access(input logic [15:0] a, input bit wr, input logic [15:0] d);
      set(2'b10, 2'b00, 2'b00, 2'b00, a); cycle();
      if (wr) begin
         set(2'b00, 2'b10, 2'b00, 2'b00, d); cycle();
         set(2'b00, 2'b00, 2'b10, 2'b00, 16'h0); cycle();
      end
      set(2'b00, 2'b00, 2'b00, wr ? 2'b10 : 2'b01, 16'h0); cycle();
      idle();
      repeat (W + 1) cycle();
      if (!wr) mdrm = 2'b01;
      cycle();
      idle();
   endtask

   initial begin
      int n;
      repeat (3) cycle();
      chk("rst_mar", 32'(mar), 32'h0);
      chk("rst_busy", 32'(mem_busy), 32'h0);
      reset = 1'b1;
      cycle();

      // Zero wait states: ACCESS in cycle 1, DONE in cycle 2
      z_mem = 2'b01; cycle(); z_mem = 2'b00;
      chk("w0_c1_busy", 32'(z_busy), 32'h1);
      chk("w0_c1_done", 32'(z_done), 32'h0);
      cycle();
      chk("w0_c2_done", 32'(z_done), 32'h1);
      cycle();
      chk("w0_c3_busy", 32'(z_busy), 32'h0);

      // Write round trip with explicit timing
      set(2'b10, 2'b00, 2'b00, 2'b00, 16'h0010); cycle();
      set(2'b00, 2'b10, 2'b00, 2'b00, 16'hBEEF); cycle();
      set(2'b00, 2'b00, 2'b10, 2'b00, 16'h0); cycle();
      set(2'b00, 2'b00, 2'b00, 2'b10, 16'h0); cycle();
      idle();
      chk("rt_c1_done", 32'(mem_done), 32'h0);
      cycle(); cycle();
      chk("rt_c3_busy", 32'(mem_busy), 32'h1);
      chk("rt_c3_done", 32'(mem_done), 32'h0);
      cycle();
      chk("rt_c4_done", 32'(mem_done), 32'h1);
      cycle();
      chk("rt_c5_busy", 32'(mem_busy), 32'h0);
      set(2'b00, 2'b10, 2'b00, 2'b00, 16'h0000); cycle(); idle();
      do_access(16'h0010, 1'b0, 16'h0);
      chk("rt_mdr", 32'(mdr), 32'hBEEF);
      mdr_mode = 2'b01; #1;
      chk("rt_bus_out", 32'(bus_out), 32'hBEEF);
      idle(); #1;

      // Write request during WAIT of a read is ignored
      set(2'b10, 2'b00, 2'b00, 2'b00, 16'h0010); cycle();
      set(2'b00, 2'b10, 2'b00, 2'b00, 16'h0BAD); cycle();
      set(2'b00, 2'b00, 2'b10, 2'b00, 16'h0); cycle();
      set(2'b00, 2'b00, 2'b00, 2'b01, 16'h0); cycle();
      mem = 2'b10; cycle(); idle();
      n = 0;
      for (int i = 0; i < W + 4; i++) begin
         if (mem_done) n++;
         cycle();
      end
      chk("ignore_done_count", 32'(n), 32'h1);
      do_access(16'h0010, 1'b0, 16'h0);
      chk("ignore_mdr", 32'(mdr), 32'hBEEF);

      // Address aliasing modulo depth
      do_access(16'h1005, 1'b1, 16'h1234);
      set(2'b00, 2'b10, 2'b00, 2'b00, 16'h0); cycle(); idle();
      do_access(16'h0005, 1'b0, 16'h0);
      chk("alias_mdr", 32'(mdr), 32'h1234);

      // Drive conflict
      set(2'b10, 2'b00, 2'b00, 2'b00, 16'h1111); cycle();
      set(2'b00, 2'b10, 2'b00, 2'b00, 16'h2222); cycle();
      set(2'b01, 2'b01, 2'b00, 2'b00, 16'h0); #1;
      chk("conf_out", 32'(bus_out), 32'h2222);
      chk("conf_err", 32'(bus_err), 32'h1);
      idle(); #1;
      chk("none_oe", 32'(bus_oe), 32'h0);
      chk("none_out", 32'(bus_out), 32'h0);

      // Reset during WAIT aborts the write
      do_access(16'h0003, 1'b1, 16'h5555);
      set(2'b10, 2'b00, 2'b00, 2'b00, 16'h0003); cycle();
      set(2'b00, 2'b10, 2'b00, 2'b00, 16'hAAAA); cycle();
      set(2'b00, 2'b00, 2'b10, 2'b00, 16'h0); cycle();
      set(2'b00, 2'b00, 2'b00, 2'b10, 16'h0); cycle();
      set(2'b00, 2'b01, 2'b00, 2'b00, 16'h0);
      reset = 1'b0; model_reset(); #1;
      chk("rst_mid_busy", 32'(mem_busy), 32'h0);
      chk("rst_mid_oe", 32'(bus_oe), 32'h0);
      chk("rst_mid_out", 32'(bus_out), 32'h0);
      chk("rst_mid_mdr", 32'(mdr), 32'h0);
      repeat (3) cycle();
      reset = 1'b1; idle(); cycle();
      do_access(16'h0003, 1'b0, 16'h0);
      chk("rst_mid_reread", 32'(mdr), 32'h5555);

      // Randomized traffic over a small, pre-written address window
      for (int a = 0; a < 8; a++) do_access(16'(a), 1'b1, 16'($urandom));
      for (int i = 0; i < 3000; i++) begin
         mar_mode = 2'($urandom);
         mdr_mode = 2'($urandom);
         mdrm     = 2'($urandom);
         mem      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         bus_in   = (mar_mode == 2'b10) ? {4'($urandom), 9'h0, 3'($urandom)} : 16'($urandom);
         cycle();
      end
      idle();
      repeat (W + 4) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/memunit.md
# memunit

Memory unit for the multi-cycle bus CPU, directly downstream of `control`. It owns MAR, MDR, a write-data latch, a read-data latch and the data memory array. It executes the `MARBusMode`, `MDRBusMode`, `MDRMemMode` and `MemMode` commands that `control` issues each cycle. Each access takes a fixed number of wait states, and the unit reports `mem_busy`/`mem_done` back so `control` can stall its sequence.

## Interface
Parameters:
- `WIDTH`, 16: word width, matching the `WORD` macro.
- `DEPTH_LOG2`, 12: memory holds 2^DEPTH_LOG2 words.
- `WAIT_STATES`, 2: wait cycles before the array access. Legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low.
- `bus_in`  in  WIDTH  value currently on the datapath bus.
- `bus_out`  out  WIDTH  value this unit drives onto the bus.
- `bus_oe`  out  1  `bus_out` is valid and must be selected onto the bus.
- `bus_err`  out  1  MAR and MDR both requested to drive this cycle.
- `MARBusMode`  in  2  MAR to/from bus command.
- `MDRBusMode`  in  2  MDR to/from bus command.
- `MDRMemMode`  in  2  MDR to/from memory-latch command.
- `MemMode`  in  2  memory access request.
- `mem_busy`  out  1  an access is in progress.
- `mem_done`  out  1  one-cycle pulse: access complete.
- `mar`  out  WIDTH  current MAR, for debug.
- `mdr`  out  WIDTH  current MDR, for debug.

## Operation
Bus modes, shared by `MARBusMode` and `MDRBusMode`:
- 00: none.
- 01: drive. Combinational: `bus_out` = register, `bus_oe` = 1.
- 10: load. Register <= `bus_in` at the edge.
- 11: reserved; treated as none.

Drive conflict:
- If MAR and MDR both drive in the same cycle, MDR wins and `bus_err` = 1 for that cycle.
- `bus_out` = 0 whenever `bus_oe` = 0.

`MDRMemMode`:
- 01: `mdr` <= rdata.
- 10: wdata <= `mdr`.
- 00 and 11: none.
- If MDR has a bus load and a memory load in the same cycle, the bus load wins.

`MemMode`:
- 01 is read, 10 is write, 00 and 11 are none.
- A request is accepted only in IDLE; requests in any other state are ignored.
- On acceptance the unit latches addr = `mar[DEPTH_LOG2-1:0]`. Upper address bits are ignored, so addresses wrap modulo the memory depth.
- A write stores wdata, not the live `mdr`.

Access state machine:
- IDLE: on an accepted request, go to WAIT with cnt = WAIT_STATES. If WAIT_STATES = 0, go straight to ACCESS.
- WAIT: cnt decrements each cycle; go to ACCESS on the edge where cnt = 1. WAIT lasts exactly WAIT_STATES cycles.
- ACCESS: one cycle. At its closing edge, a write updates the array and a read loads rdata. Then go to DONE.
- DONE: one cycle with `mem_done` = 1. Then go to IDLE.
- `mem_busy` = 1 in WAIT, ACCESS and DONE.

Other rules:
- MAR, MDR and wdata may be loaded during WAIT or ACCESS. This does not affect the access in flight, because the address is latched and the write uses wdata.

Reset (`reset` = 0), asynchronous:
- State goes to IDLE; cnt, `mar`, `mdr`, wdata, rdata and addr all clear to 0.
- All outputs are 0.
- Array contents are not reset.
- Reset asserted before the closing edge of ACCESS aborts the access: no array write and no rdata update.

## Timing
- Request sampled at edge 0: WAIT spans cycles 1..W, ACCESS is cycle W+1, DONE is cycle W+2, IDLE returns at W+3. With W = 2, `mem_done` is high in cycle 4.
- rdata is valid from DONE onward. `MDRMemMode` = 01 issued in DONE loads the new data at the end of that cycle.
- Earliest back-to-back request: issued in the first IDLE cycle after DONE, giving a throughput of one access per W+3 cycles.
- Bus drive, `bus_oe` and `bus_err` are combinational from the mode inputs, with zero latency. All loads take effect at the edge.

## Structure
- Shared defines header, also included by `control`:
  - `WORD`;
  - bus-mode encodings `BUS_NONE`/`BUS_DRIVE`/`BUS_LOAD`;
  - `MDRMemMode` encodings `MDRM_NONE`/`MDRM_FROM_MEM`/`MDRM_TO_WDATA`;
  - `MemMode` encodings `MEM_NONE`/`MEM_READ`/`MEM_WRITE`;
  - state encodings.
- Sub-module `memunit_ram`: single-port synchronous array with parameters WIDTH and DEPTH_LOG2, inputs we/addr/wdata, registered rdata.
- `memunit` holds the registers, the FSM, the counter and the bus mux.

## Test plan
- Write/read round trip, W = 2. MAR <- 0x0010 from the bus; MDR <- 0xBEEF; `MDRMemMode` = 10; `MemMode` = 10. Expect `mem_done` in cycle 4. Then `MemMode` = 01 at the same address, and `MDRMemMode` = 01 in DONE. Expect `mdr` = 0xBEEF and MDR driving the bus gives `bus_out` = 0xBEEF.
- Busy-ignore: issue `MemMode` = 10 during WAIT of a read. Expect the FSM unaffected, exactly one `mem_done`, and no array write.
- Aliasing, DEPTH_LOG2 = 12: write 0x1234 at MAR = 0x1005, read MAR = 0x0005. Expect 0x1234.
- Conflict: MARBusMode = MDRBusMode = 01 with `mar` = 0x1111, `mdr` = 0x2222. Expect `bus_out` = 0x2222 and `bus_err` = 1. All modes 00: expect `bus_oe` = 0 and `bus_out` = 0.
- Reset mid-operation: assert `reset` low in WAIT of a write of 0xAAAA to address 3 (previously 0x5555). Expect all outputs 0 immediately. Re-reading address 3 returns 0x5555.
- WAIT_STATES = 0: a request at edge 0 gives ACCESS in cycle 1 and `mem_done` in cycle 2.
